// File: rtl/fetch_if_pkg.sv
`default_nettype none
// ============================================================================
// fetch_if_pkg : shared types and constants for the instruction fetch unit
// Revision 1.0 - initial release
// ============================================================================
package fetch_if_pkg;

   localparam int unsigned INSTR_W          = 16;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_WAIT  = 3'd1,
      S_ISSUE = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } fetch_state_t;

endpackage : fetch_if_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// fetch_if : fetches 32-bit words and presents them as two 16-bit instructions
// Revision 1.0 - initial release
// ============================================================================
module fetch_if
   import fetch_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               branch_i,
   input  logic [31:0]        branch_target_i,
   input  logic               end_program_i,
   output logic               imem_req_o,
   output logic [31:0]        imem_addr_o,
   input  logic [31:0]        imem_rdata_i,
   input  logic               imem_valid_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic               instr_en_o,
   output logic [31:0]        next_programm_counter_o
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  word_q, word_d;
   logic [31:0]  w_pc_plus2;
   logic [31:0]  w_target;
   logic         w_unused_target_lsb;

   assign w_pc_plus2          = pc_q + 32'd2;
   assign w_target            = {branch_target_i[31:1], 1'b0};
   assign w_unused_target_lsb = branch_target_i[0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_REQ;
         pc_q    <= {RESET_PC[31:1], 1'b0};
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      word_d  = word_q;
      if (end_program_i) begin
         state_d = S_HALT;
      end else begin
         case (state_q)
            S_REQ: begin
               // The request already went out this cycle, so its response must be drained.
               if (branch_i) begin
                  pc_d    = w_target;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (branch_i) begin
                  pc_d    = w_target;
                  state_d = imem_valid_i ? S_REQ : S_DRAIN;
               end else if (imem_valid_i) begin
                  word_d  = imem_rdata_i;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (branch_i) begin
                  pc_d    = w_target;
                  state_d = S_REQ;
               end else if (!stall_i) begin
                  pc_d    = w_pc_plus2;
                  state_d = pc_q[1] ? S_REQ : S_ISSUE;
               end
            end
            S_DRAIN: begin
               if (branch_i) begin
                  pc_d = w_target;
               end
               if (imem_valid_i) begin
                  state_d = S_REQ;
               end
            end
            S_HALT: begin
               state_d = S_HALT;
            end
            default: begin
               state_d = S_REQ;
            end
         endcase
      end
   end

   // Reset masks the request so a held reset never launches a read.
   assign imem_req_o              = (state_q == S_REQ) && !rst_i;
   assign imem_addr_o             = {pc_q[31:2], 2'b00};
   assign instr_en_o              = (state_q == S_ISSUE);
   assign instr_o                 = pc_q[1] ? word_q[31:16] : word_q[15:0];
   assign next_programm_counter_o = w_pc_plus2;

endmodule : fetch_if
`default_nettype wire

// File: tb/tb_fetch_if.sv
`default_nettype none
// ============================================================================
// tb_fetch_if : scoreboard bench for fetch_if with a variable-latency memory
// Revision 1.0 - initial release
// ============================================================================
module tb_fetch_if;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        end_program_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i = '0;
   logic        imem_valid_i = 1'b0;
   logic [15:0] instr_o;
   logic        instr_en_o;
   logic [31:0] next_programm_counter_o;

   int          n_cmp = 0;
   int          n_err = 0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   int          halt_req, halt_en;
   logic [47:0] ins_e;

   logic [31:0] exp_req_q[$];
   logic [47:0] exp_ins_q[$];

   fetch_if #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .stall_i                 (stall_i),
      .branch_i                (branch_i),
      .branch_target_i         (branch_target_i),
      .end_program_i           (end_program_i),
      .imem_req_o              (imem_req_o),
      .imem_addr_o             (imem_addr_o),
      .imem_rdata_i            (imem_rdata_i),
      .imem_valid_i            (imem_valid_i),
      .instr_o                 (instr_o),
      .instr_en_o              (instr_en_o),
      .next_programm_counter_o (next_programm_counter_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Halfword stored at byte address pc; word 0 carries the reference pattern.
   function automatic logic [15:0] half_at(input logic [31:0] pc);
      if (pc[31:2] == 30'd0) return pc[1] ? 16'h2202 : 16'h2101;
      return pc[15:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:2], 2'b00};
      return {half_at(base + 32'd2), half_at(base)};
   endfunction

   task automatic push_ins(input logic [31:0] pc);
      exp_ins_q.push_back({half_at(pc), pc + 32'd2});
   endtask

   // Memory model and scoreboard, sampled between clock edges.
   always @(negedge clk_i) begin
      #1;
      imem_valid_i = 1'b0;
      if (rst_i) begin
         mem_cnt = 0;
      end else begin
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               imem_valid_i = 1'b1;
               imem_rdata_i = mem_word(mem_addr);
            end
         end
         if (imem_req_o) begin
            check_value("req_overlap", mem_cnt, 0);
            if (exp_req_q.size() > 0) check_value("req_addr", imem_addr_o, exp_req_q.pop_front());
            mem_cnt  = mem_lat;
            mem_addr = imem_addr_o;
         end
         if (instr_en_o && !stall_i && !branch_i && !end_program_i && exp_ins_q.size() > 0) begin
            ins_e = exp_ins_q.pop_front();
            check_value("instr", {16'h0, instr_o}, {16'h0, ins_e[47:32]});
            check_value("next_pc", next_programm_counter_o, ins_e[31:0]);
         end
      end
   end

   task automatic reset_begin();
      @(negedge clk_i);
      rst_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; end_program_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #2;
      check_value("rst_en", {31'h0, instr_en_o}, 32'h0);
      check_value("rst_req", {31'h0, imem_req_o}, 32'h0);
      check_value("rst_instr", {16'h0, instr_o}, 32'h0);
      check_value("rst_npc", next_programm_counter_o, 32'h2);
      exp_req_q.delete();
      exp_ins_q.delete();
   endtask

   task automatic reset_end();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic sb_done(input int n);
      repeat (n) @(negedge clk_i);
      check_value("sb_req_left", exp_req_q.size(), 0);
      check_value("sb_ins_left", exp_ins_q.size(), 0);
   endtask

   task automatic expect_req(input string tag, input logic [31:0] addr);
      check_value(tag, {31'h0, imem_req_o}, 32'h1);
      check_value(tag, imem_addr_o, addr);
   endtask

   task automatic expect_ins(input string tag, input logic [15:0] ins, input logic [31:0] npc);
      check_value(tag, {31'h0, instr_en_o}, 32'h1);
      check_value(tag, {16'h0, instr_o}, {16'h0, ins});
      check_value(tag, next_programm_counter_o, npc);
   endtask

   initial begin
      // Basic fetch, 1-cycle memory
      mem_lat = 1;
      reset_begin();
      exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
      push_ins(32'h0); push_ins(32'h2); push_ins(32'h4); push_ins(32'h6);
      reset_end();
      #2 expect_req("t1_req_c1", 32'h0);
      repeat (2) @(negedge clk_i);
      #2 expect_ins("t1_ins_c3", 16'h2101, 32'h2);
      @(negedge clk_i);
      #2 expect_ins("t1_ins_c4", 16'h2202, 32'h4);
      @(negedge clk_i);
      #2 expect_req("t1_req_c5", 32'h4);
      sb_done(10);

      // Stall holds the presented upper half
      reset_begin();
      exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4);
      push_ins(32'h0); push_ins(32'h2); push_ins(32'h4);
      reset_end();
      repeat (3) @(negedge clk_i);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2 expect_ins("t2_stall", 16'h2202, 32'h4);
         @(negedge clk_i);
      end
      stall_i = 1'b0;
      #2 expect_ins("t2_release", 16'h2202, 32'h4);
      @(negedge clk_i);
      #2 expect_req("t2_req_next", 32'h4);
      sb_done(6);

      // Branch while waiting, 3-cycle memory: stale word drained
      mem_lat = 3;
      reset_begin();
      exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h10); exp_req_q.push_back(32'h14);
      push_ins(32'h12); push_ins(32'h14);
      reset_end();
      @(negedge clk_i);
      branch_i = 1'b1; branch_target_i = 32'h0000_0013;
      @(negedge clk_i);
      branch_i = 1'b0;
      #2 check_value("t3_drain_en", {31'h0, instr_en_o}, 32'h0);
      check_value("t3_drain_req", {31'h0, imem_req_o}, 32'h0);
      @(negedge clk_i);
      #2 check_value("t3_drain_req2", {31'h0, imem_req_o}, 32'h0);
      @(negedge clk_i);
      #2 expect_req("t3_req_target", 32'h10);
      check_value("t3_en_c5", {31'h0, instr_en_o}, 32'h0);
      repeat (4) @(negedge clk_i);
      #2 expect_ins("t3_upper_first", half_at(32'h12), 32'h14);
      sb_done(8);

      // Branch coincident with valid in S_WAIT
      mem_lat = 1;
      reset_begin();
      exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h40);
      push_ins(32'h40); push_ins(32'h42);
      reset_end();
      @(negedge clk_i);
      branch_i = 1'b1; branch_target_i = 32'h0000_0040;
      @(negedge clk_i);
      branch_i = 1'b0;
      #2 expect_req("t4_req_target", 32'h40);
      check_value("t4_dropped", {31'h0, instr_en_o}, 32'h0);
      repeat (2) @(negedge clk_i);
      #2 expect_ins("t4_ins", half_at(32'h40), 32'h42);
      sb_done(4);

      // End of program beats branch; late response ignored
      mem_lat = 2;
      reset_begin();
      exp_req_q.push_back(32'h0);
      reset_end();
      @(negedge clk_i);
      end_program_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h0000_0080;
      @(negedge clk_i);
      end_program_i = 1'b0; branch_i = 1'b0;
      halt_req = 0; halt_en = 0;
      for (int i = 0; i < 20; i++) begin
         #2;
         if (imem_req_o) halt_req++;
         if (instr_en_o) halt_en++;
         @(negedge clk_i);
      end
      check_value("t5_halt_req", halt_req, 0);
      check_value("t5_halt_en", halt_en, 0);
      sb_done(0);
      reset_begin();
      exp_req_q.push_back(32'h0);
      reset_end();
      #2 expect_req("t5_restart", 32'h0);
      sb_done(2);

      // Wrap-around at the top of the address space
      mem_lat = 1;
      reset_begin();
      exp_req_q.push_back(32'h0); exp_req_q.push_back(32'hFFFF_FFFC); exp_req_q.push_back(32'h0);
      push_ins(32'hFFFF_FFFC); push_ins(32'hFFFF_FFFE); push_ins(32'h0);
      reset_end();
      repeat (2) @(negedge clk_i);
      branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
      #2 expect_ins("t6_branch_cycle", 16'h2101, 32'h2);
      @(negedge clk_i);
      branch_i = 1'b0;
      #2 expect_req("t6_req_top", 32'hFFFF_FFFC);
      repeat (2) @(negedge clk_i);
      #2 expect_ins("t6_ins_fffc", half_at(32'hFFFF_FFFC), 32'hFFFF_FFFE);
      @(negedge clk_i);
      #2 expect_ins("t6_ins_fffe", half_at(32'hFFFF_FFFE), 32'h0);
      @(negedge clk_i);
      #2 expect_req("t6_req_wrap", 32'h0);
      sb_done(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fetch_if
`default_nettype wire

// File: doc/fetch_if.md
FETCH_IF -- requirements
Module: fetch_if

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first instruction after reset.
REQ-002 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 stall_i  in  1  decode cannot accept the presented instruction this cycle.
REQ-005 branch_i  in  1  redirect request from execute, one-cycle pulse.
REQ-006 branch_target_i  in  32  redirect byte address; bit 0 ignored.
REQ-007 end_program_i  in  1  decode reached the program-end instruction.
REQ-008 imem_req_o  out  1  one-cycle instruction-memory read request.
REQ-009 imem_addr_o  out  32  word address of the request, bits [1:0] = 0.
REQ-010 imem_rdata_i  in  32  read data, qualified by imem_valid_i.
REQ-011 imem_valid_i  in  1  read data valid, at least 1 cycle after the request.
REQ-012 instr_o  out  16  presented instruction; feeds decode instr_i.
REQ-013 instr_en_o  out  1  instr_o valid; feeds decode instr_en_i.
REQ-014 next_programm_counter_o  out  32  address of presented instruction + 2.

Function
REQ-015 State machine SHALL have states S_REQ, S_WAIT, S_ISSUE, S_DRAIN and S_HALT.
REQ-016 Register pc holds the current instruction address; pc[0] SHALL always be 0; pc+2 wraps 0xFFFF_FFFE -> 0x0000_0000.
REQ-017 imem_req_o SHALL be 1 only in S_REQ, with imem_addr_o = {pc[31:2],2'b00}; S_REQ -> S_WAIT unconditionally.
REQ-018 At most one memory request SHALL be outstanding.
REQ-019 S_WAIT on imem_valid_i: store imem_rdata_i in the word buffer; -> S_ISSUE.
REQ-020 instr_en_o SHALL be 1 exactly in S_ISSUE; instr_o = pc[1] ? word[31:16] : word[15:0] (little-endian).
REQ-021 Outputs SHALL derive from registers only, with no combinational path from any input.
REQ-022 Consume = S_ISSUE & ~stall_i; pc <= pc+2; if old pc[1]=0 stay in S_ISSUE (upper half), else -> S_REQ.
REQ-023 While stall_i=1, instr_o, instr_en_o and next_programm_counter_o SHALL hold stable; stall_i SHALL NOT block S_REQ/S_WAIT progress.
REQ-024 branch_i SHALL set pc <= {branch_target_i[31:1],1'b0} in any state except S_HALT.
REQ-025 On branch_i: S_ISSUE -> S_REQ; S_REQ or S_WAIT without imem_valid_i -> S_DRAIN; S_WAIT with imem_valid_i in the same cycle -> S_REQ, data discarded.
REQ-026 branch_i has priority over stall_i; the instruction presented in the branch cycle SHALL NOT count as consumed.
REQ-027 S_DRAIN SHALL discard the response on imem_valid_i and then -> S_REQ; a further branch_i in S_DRAIN only updates pc.
REQ-028 end_program_i SHALL force -> S_HALT from any state, with priority over branch_i and stall_i.
REQ-029 S_HALT is left only by reset; in it imem_req_o=0, instr_en_o=0, and late responses are ignored.
REQ-030 Latency: request in cycle N, imem_valid_i in cycle N+k (k>=1), instr_en_o=1 in cycle N+k+1.

Reset
REQ-031 rst_i SHALL set state=S_REQ, pc=RESET_PC, word buffer=0, instr_en_o=0, imem_req_o=0 during reset, instr_o=16'h0000, next_programm_counter_o=RESET_PC+2.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request; the memory SHALL NOT return data for it after reset.
REQ-033 The first request SHALL be issued in the first cycle after rst_i deasserts.

Structure
REQ-034 Shared package SHALL hold fetch_state_t (state enum), RESET_PC default and INSTR_W=16.
REQ-035 Single module, no sub-module; about 150-250 RTL lines.

Verification
REQ-036 Reset, 1-cycle memory, word 0x2202_2101: req addr 0x0 in cycle 1; cycle 3 instr 0x2101, next PC 0x2; cycle 4 instr 0x2202, next PC 0x4; cycle 5 req addr 0x4.
REQ-037 stall_i=1 for 3 cycles while instr_o=0x2202: outputs stable for all 3 cycles; pc advances only after stall_i drops.
REQ-038 branch_i target 0x0000_0013 while waiting with 3-cycle latency: stale word discarded (S_DRAIN); next req addr 0x10; first instr is the upper half (pc=0x12).
REQ-039 branch_i and imem_valid_i in the same cycle in S_WAIT: data dropped; req issued next cycle at target.
REQ-040 end_program_i with branch_i asserted: S_HALT; no further imem_req_o, instr_en_o=0 for 20 cycles; reset restarts at RESET_PC.
REQ-041 Wrap-around, branch target 0xFFFF_FFFC: instrs at 0xFFFF_FFFC and 0xFFFF_FFFE, then req addr 0x0000_0000.
